eq_out_requant_buf: RTL and testbench

- Sits directly downstream of the equaliser FIR MAC stage.
- Takes the wide signed accumulator result y(n) and rounds it to a 16-bit Q1.15 sample, saturating where needed.
- Buffers the samples in a small FIFO and presents them on a valid/ready stream to the capture/DAC side, whose samples are later post-processed for THD.
- Counts saturation events and flags dropped samples.

---
 rtl/eq_pkg.sv | 19 +
 rtl/eq_sync_fifo.sv | 66 ++++++
 rtl/eq_out_requant_buf.sv | 119 +++++++++++
 tb/tb_eq_out_requant_buf.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/eq_pkg.sv
// eq_pkg -- shared widths, sample types and Q1.15 limits for the equaliser output path. Rev 1.0
`default_nettype none

package eq_pkg;

  localparam int EQ_ACC_W    = 40;
  localparam int EQ_ACC_FRAC = 30;
  localparam int EQ_OUT_W    = 16;
  localparam int EQ_OUT_FRAC = 15;

  typedef logic signed [EQ_ACC_W-1:0] acc_t;
  typedef logic signed [EQ_OUT_W-1:0] sample_t;

  localparam sample_t SAMPLE_MAX = 16'sh7FFF;
  localparam sample_t SAMPLE_MIN = 16'sh8000;

endpackage

`default_nettype wire

// File: rtl/eq_sync_fifo.sv
// eq_sync_fifo -- first-word-fall-through synchronous FIFO; rdata reads 0 while empty. Rev 1.0
`default_nettype none

module eq_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             w_push;
  logic             w_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == LW'(DEPTH));
  assign level = level_q;
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

  // A write into a full FIFO is only legal when the head leaves in the same cycle.
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (w_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (w_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (w_push && !w_pop)      level_d = level_q + LW'(1);
    else if (w_pop && !w_push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/eq_out_requant_buf.sv
// eq_out_requant_buf -- rounds/saturates FIR accumulator output to Q1.15, buffers it, counts clamps and drops. Rev 1.0
`default_nettype none

module eq_out_requant_buf
  import eq_pkg::*;
#(
  parameter int ACC_W    = EQ_ACC_W,
  parameter int ACC_FRAC = EQ_ACC_FRAC,
  parameter int OUT_W    = EQ_OUT_W,
  parameter int OUT_FRAC = EQ_OUT_FRAC,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [ACC_W-1:0]           in_acc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic [CNT_W-1:0]           sat_cnt,
  output logic                       ovf_flag,
  input  logic                       clr
);

  localparam int SH = ACC_FRAC - OUT_FRAC;
  localparam logic [ACC_W:0]        c_half = (ACC_W+1)'(1) << (SH - 1);
  localparam logic signed [ACC_W:0] c_max  = (ACC_W+1)'((longint'(1) << (OUT_W - 1)) - 1);
  localparam logic signed [ACC_W:0] c_min  = (ACC_W+1)'(-(longint'(1) << (OUT_W - 1)));

  logic signed [ACC_W:0] w_ext;
  logic signed [ACC_W:0] w_sum;
  logic signed [ACC_W:0] w_r;
  logic                  s1_valid_q;
  logic signed [ACC_W:0] s1_r_q;
  logic                  w_sat_hi;
  logic                  w_sat_lo;
  logic                  w_sat_evt;
  logic [OUT_W-1:0]      w_sample;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  logic [CNT_W-1:0]      sat_cnt_q, sat_cnt_d;
  logic                  ovf_q, ovf_d;

  // One extra bit of headroom keeps the rounding add from wrapping at the positive limit.
  assign w_ext = {in_acc[ACC_W-1], in_acc};
  assign w_sum = w_ext + $signed(c_half);
  assign w_r   = w_sum >>> SH;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_r_q     <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) s1_r_q <= w_r;
    end
  end

  assign w_sat_hi  = (s1_r_q > c_max);
  assign w_sat_lo  = (s1_r_q < c_min);
  assign w_sat_evt = s1_valid_q & (w_sat_hi | w_sat_lo);
  assign w_sample  = w_sat_hi ? {1'b0, {(OUT_W-1){1'b1}}} :
                     w_sat_lo ? {1'b1, {(OUT_W-1){1'b0}}} :
                     s1_r_q[OUT_W-1:0];

  assign out_valid = ~w_empty;
  assign w_pop     = out_valid & out_ready;
  assign w_push    = s1_valid_q & (~w_full | w_pop);
  assign w_drop    = s1_valid_q & w_full & ~w_pop;

  eq_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (w_push),
    .wdata (w_sample),
    .pop   (w_pop),
    .rdata (out_data),
    .level (level),
    .full  (w_full),
    .empty (w_empty)
  );

  // clr wins over a same-cycle event; that event is deliberately lost.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    ovf_d     = ovf_q;
    if (clr) begin
      sat_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (w_sat_evt && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + CNT_W'(1);
      if (w_drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  assign sat_cnt  = sat_cnt_q;
  assign ovf_flag = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_eq_out_requant_buf.sv
// tb_eq_out_requant_buf -- directed plus randomized bench against a queue-based reference model. Rev 1.0
`default_nettype none

module tb_eq_out_requant_buf;
  import eq_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [39:0] in_acc = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [15:0]        out_data;
  logic [4:0]         level;
  logic [15:0]        sat_cnt;
  logic               ovf_flag;
  logic               clr = 1'b0;

  int total = 0;
  int bad   = 0;

  eq_out_requant_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_acc    (in_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .level     (level),
    .sat_cnt   (sat_cnt),
    .ovf_flag  (ovf_flag),
    .clr       (clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: round half up to 2^-15 then clamp to the Q1.15 range; bit 16 flags a clamp.
  function automatic logic [16:0] ref_q(input longint a);
    longint r;
    r = (a + 64'sd16384) >>> 15;
    if (r > 32767)       return {1'b1, SAMPLE_MAX};
    else if (r < -32768) return {1'b1, SAMPLE_MIN};
    else                 return {1'b0, 16'(r)};
  endfunction

  logic [15:0] mq[$];
  bit          m_pv   = 1'b0;
  logic [15:0] m_pval = '0;
  bit          m_psat = 1'b0;
  int          m_sat  = 0;
  bit          m_ovf  = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_pv = 1'b0; m_pval = '0; m_psat = 1'b0; m_sat = 0; m_ovf = 1'b0;
    end else begin
      int lvl;
      bit do_pop, dropped;
      logic [16:0] q;
      lvl     = mq.size();
      do_pop  = (lvl > 0) && out_ready;
      dropped = 1'b0;
      if (do_pop) void'(mq.pop_front());
      if (m_pv) begin
        if (lvl < 16 || do_pop) mq.push_back(m_pval);
        else dropped = 1'b1;
      end
      if (clr) begin
        m_sat = 0; m_ovf = 1'b0;
      end else begin
        if (m_pv && m_psat && m_sat != 65535) m_sat++;
        if (dropped) m_ovf = 1'b1;
      end
      q      = ref_q(longint'(in_acc));
      m_pv   = in_valid;
      m_pval = q[15:0];
      m_psat = q[16];
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_out_valid", 64'(out_valid), 64'(mq.size() != 0));
      chk("m_out_data",  64'(out_data),  64'(mq.size() != 0 ? mq[0] : 16'h0));
      chk("m_level",     64'(level),     64'(mq.size()));
      chk("m_sat_cnt",   64'(sat_cnt),   64'(m_sat));
      chk("m_ovf_flag",  64'(ovf_flag),  64'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic signed [39:0] a);
    in_valid = 1'b1; in_acc = a;
    tick();
    in_valid = 1'b0;
  endtask

  // Single sample with out_ready=1: visible on the negedge of cycle t+2.
  task automatic send_check(input string name, input logic signed [39:0] a, input logic [15:0] exp);
    send(a);
    @(posedge clk); @(negedge clk);
    chk(name, 64'(out_data), 64'(exp));
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(); clr = 1'b0;
  endtask

  function automatic logic signed [39:0] gen_acc();
    longint v;
    case ($urandom % 4)
      0: v = longint'($urandom_range(0, 131072)) - 65536;
      1: begin
        v = (longint'(1) << 30) + longint'($urandom_range(0, 65536)) - 32768;
        if ($urandom % 2) v = -v;
      end
      2: v = ((longint'($urandom) << 32) | longint'($urandom)) <<< 24 >>> 24;
      default: v = ((longint'($urandom_range(0, 65535)) - 32768) <<< 15) + (($urandom % 2) ? 16384 : 0);
    endcase
    return 40'(v);
  endfunction

  initial begin
    logic [16:0] q;

    // Model pins
    q = ref_q(64'sh20000000);   chk("ref_half",   64'(q), 64'h04000);
    q = ref_q(64'sh4000);       chk("ref_tie_up", 64'(q), 64'h00001);
    q = ref_q(-64'sh4001);      chk("ref_neg",    64'(q), 64'h0FFFF);
    q = ref_q(64'sh40000000);   chk("ref_sat_hi", 64'(q), 64'h17FFF);

    #12;
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data",  64'(out_data),  64'h0);
    chk("rst_level",     64'(level),     64'h0);
    chk("rst_sat_cnt",   64'(sat_cnt),   64'h0);
    chk("rst_ovf",       64'(ovf_flag),  64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    out_ready = 1'b1;
    send_check("nominal_half", 40'sh0020000000, 16'h4000);
    chk("nominal_sat_cnt", 64'(sat_cnt), 64'h0);
    send_check("round_4000",  40'sh4000,  16'h0001);
    send_check("round_3fff",  40'sh3FFF,  16'h0000);
    send_check("round_m4000", -40'sh4000, 16'h0000);
    send_check("round_m4001", -40'sh4001, 16'hFFFF);
    send_check("sat_pos", 40'sh0040000000, 16'h7FFF);
    chk("sat_cnt_1", 64'(sat_cnt), 64'h1);
    send_check("sat_neg", -40'sh0080000000, 16'h8000);
    chk("sat_cnt_2", 64'(sat_cnt), 64'h2);
    pulse_clr();
    @(negedge clk);
    chk("clr_sat_cnt", 64'(sat_cnt), 64'h0);
    tick();

    // Overflow: 17 samples into a 16-deep FIFO with no reader
    out_ready = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      in_valid = 1'b1; in_acc = 40'(k) <<< 15; tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("ovf_level", 64'(level), 64'd16);
    chk("ovf_flag_set", 64'(ovf_flag), 64'h1);
    tick();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk("drain_data", 64'(out_data), 64'(k));
      tick();
    end
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'h0);
    tick();
    pulse_clr();

    // Full with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_acc = 40'(k) <<< 15; tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_acc = 40'(99) <<< 15; tick();
    in_valid = 1'b0; out_ready = 1'b1; tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("pp_level", 64'(level), 64'd16);
    chk("pp_ovf", 64'(ovf_flag), 64'h0);
    tick();
    out_ready = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      chk("pp_drain", 64'(out_data), (k == 17) ? 64'd99 : 64'(k));
      tick();
    end

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      int rp;
      rp = ((c / 250) % 3 == 0) ? 20 : ((c / 250) % 3 == 1) ? 60 : 95;
      in_valid  = ($urandom % 4) != 0;
      in_acc    = gen_acc();
      out_ready = ($urandom % 100) < rp;
      clr       = ($urandom % 97) == 0;
      tick();
    end
    in_valid = 1'b0; clr = 1'b0;

    // Reset mid-stream: level 5 plus two samples in flight
    out_ready = 1'b1;
    repeat (20) tick();
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      in_valid = 1'b1; in_acc = 40'(k) <<< 15; tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    in_valid = 1'b1; in_acc = 40'(6) <<< 15; tick();
    in_acc = 40'(7) <<< 15; tick();
    chk("pre_rst_level", 64'(level), 64'd6);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'h0);
    chk("mid_rst_level",     64'(level),     64'h0);
    chk("mid_rst_out_data",  64'(out_data),  64'h0);
    in_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("post_rst_idle", 64'(out_valid), 64'h0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
